fwd_hazard_unit: RTL

Forwarding and hazard-detection controller for the 5-stage MIPS pipeline. Compares the source registers of the instruction in ID against the destinations held in ID/EX, EX/MEM and MEM/WB. Registers 2-bit select codes into the EX stage, where they drive the two ALU-operand 4:1 muxes. Stalls IF/ID and injects a bubble into ID/EX on a load-use hazard.

---
 rtl/fwd_hazard_unit.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding / load-use hazard controller for a 5-stage MIPS pipeline
//
// Purpose:
//   Compares the ID-stage source registers against the destinations in
//   ID/EX, EX/MEM and MEM/WB. It registers the operand-mux selects into EX.
//   On a load-use hazard it stalls IF/ID and flushes ID/EX.
//
// Build option:
//   FWD_HAZARD_FORWARDING_EN  defined   -> full forwarding; only load-use stalls
//                             undefined -> interlock-only; selects tied to 00, and
//                                          any RAW dependence stalls until the
//                                          producer leaves WB
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt      ID-stage sources and their use bits
//   idex_rd/regwrite/memread        producer in EX
//   exmem_rd/regwrite               producer in MEM
//   memwb_rd/regwrite               producer in WB
//   fwd_a_sel, fwd_b_sel            registered operand selects (00 RF, 01 EX/MEM,
//                                   10 MEM/WB, 11 WB-late)
//   stall, idex_flush               combinational stall / bubble request
//   stall_count                     saturating count of stalled cycles

module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_regwrite,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              idex_flush,
    output logic [CNT_W-1:0]  stall_count
);

    typedef enum logic [0:0] {
        NORM     = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    localparam logic [1:0] SEL_RF     = 2'b00;
    localparam logic [1:0] SEL_EXMEM  = 2'b01;
    localparam logic [1:0] SEL_MEMWB  = 2'b10;
    localparam logic [1:0] SEL_WBLATE = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        sel_a_q, sel_a_d;
    logic [1:0]        sel_b_q, sel_b_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic a_idex, a_exmem, a_memwb;
    logic b_idex, b_exmem, b_memwb;
    logic lu_hazard;
    logic hazard;

    // Register 0 is hardwired to zero, so a write to it is never a real producer.
    function automatic logic src_match(
        input logic [REG_AW-1:0] src,
        input logic              use_bit,
        input logic [REG_AW-1:0] rd,
        input logic              regwrite
    );
        return use_bit && regwrite && (src == rd) && (src != '0);
    endfunction

    always_comb begin
        a_idex  = src_match(id_rs, id_use_rs, idex_rd,  idex_regwrite);
        a_exmem = src_match(id_rs, id_use_rs, exmem_rd, exmem_regwrite);
        a_memwb = src_match(id_rs, id_use_rs, memwb_rd, memwb_regwrite);
        b_idex  = src_match(id_rt, id_use_rt, idex_rd,  idex_regwrite);
        b_exmem = src_match(id_rt, id_use_rt, exmem_rd, exmem_regwrite);
        b_memwb = src_match(id_rt, id_use_rt, memwb_rd, memwb_regwrite);

        // A load's data only exists after MEM, so an idex match on a load
        // cannot be forwarded in time.
        lu_hazard = idex_memread && (a_idex || b_idex);
`ifdef FWD_HAZARD_FORWARDING_EN
        hazard = lu_hazard && !rst;
`else
        // Without forwarding every outstanding producer blocks the reader;
        // lu_hazard is a subset of these and is kept for uniformity.
        hazard = (lu_hazard || a_idex || a_exmem || a_memwb
                  || b_idex || b_exmem || b_memwb) && !rst;
`endif
    end

    assign stall      = hazard;
    assign idex_flush = hazard;

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORM:     state_d = hazard ? LU_STALL : NORM;
            LU_STALL: state_d = hazard ? LU_STALL : NORM;
            default:  state_d = NORM;
        endcase
    end

    always_comb begin
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
`ifdef FWD_HAZARD_FORWARDING_EN
        // Nearest producer wins; each stage's data is one hop further along
        // when this instruction reaches EX, hence the one-stage shift in codes.
        if (!hazard) begin
            if (a_idex)       sel_a_d = SEL_EXMEM;
            else if (a_exmem) sel_a_d = SEL_MEMWB;
            else if (a_memwb) sel_a_d = SEL_WBLATE;

            if (b_idex)       sel_b_d = SEL_EXMEM;
            else if (b_exmem) sel_b_d = SEL_MEMWB;
            else if (b_memwb) sel_b_d = SEL_WBLATE;
        end
`endif
    end

    always_comb begin
        count_d = count_q;
        if (hazard && !(&count_q)) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= NORM;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            count_q <= count_d;
        end
    end

    assign fwd_a_sel   = sel_a_q;
    assign fwd_b_sel   = sel_b_q;
    assign stall_count = count_q;

endmodule
